// File: rtl/alu_issue_if.sv
// alu_issue_if: groups the buses around alu_issue.
//   instruction handshake : instr_valid, instr_ready, instr
//   ALU operand bus       : alu_rs1, alu_rs2, alu_funct3, alu_funct7
//   ALU result bus        : alu_rd, alu_z
//   writeback/status      : wb_valid, wb_addr, wb_data, illegal
// The slave modport is the issue block itself.
// The master modport is everything around it (fetch, the ALU and any writeback observer).
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_rd;
    logic            alu_z;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            illegal;

    modport slave (
        input  instr_valid, instr, alu_rd, alu_z,
        output instr_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
               wb_valid, wb_addr, wb_data, illegal
    );

    modport master (
        output instr_valid, instr, alu_rd, alu_z,
        input  instr_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7,
               wb_valid, wb_addr, wb_data, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: instruction-side driver for a registered RV32I ALU.
// It accepts one ALU instruction at a time and decodes it (R-type and I-type ALU ops).
// It reads operands from its internal register file and drives the ALU.
// One cycle later it writes the ALU result back.
// The FSM walks IDLE -> DECODE -> EXEC -> WB, giving one instruction per 4 cycles.
//
// Ports:
//   clk, rst  : rising-edge clock; asynchronous active-high reset
//   bus       : alu_issue_if.slave (handshake, ALU operand/result, writeback, illegal)
//   dbg_addr  : debug register-file read address
//   dbg_data  : combinational reg[dbg_addr], 0 for address 0
//   z_flag    : only with ALU_ZFLAG_EN defined; ALU zero flag latched at each writeback
//
// Optional feature macro: ALU_ZFLAG_EN. When it is undefined, alu_z is ignored.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_if.slave      bus,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
`ifdef ALU_ZFLAG_EN
    ,
    output logic            z_flag
`endif
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t          state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] regs [NREG];

    logic            dec_legal;
    logic [XLEN-1:0] dec_rs1;
    logic [XLEN-1:0] dec_rs2;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;

    // Ready is masked by rst so it reads 0 throughout reset.
    // It rises as soon as reset is released.
    assign bus.instr_ready = (state == IDLE) && !rst;

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

`ifndef ALU_ZFLAG_EN
    logic unused_alu_z;
    assign unused_alu_z = bus.alu_z;
`endif

    // Decode of the captured instruction. ADDI never produces SUB.
    // For I-type ops, funct7 is taken from the immediate only for the shift-right pair.
    always_comb begin
        dec_legal  = 1'b0;
        dec_rs1    = (instr_q[19:15] == 5'd0) ? '0 : regs[instr_q[19:15]];
        dec_rs2    = '0;
        dec_funct3 = instr_q[14:12];
        dec_funct7 = 7'h00;
        case (instr_q[6:0])
            OP_R: begin
                dec_legal  = (instr_q[31:25] == 7'h00) || (instr_q[31:25] == 7'h20);
                dec_rs2    = (instr_q[24:20] == 5'd0) ? '0 : regs[instr_q[24:20]];
                dec_funct7 = instr_q[31:25];
            end
            OP_I: begin
                dec_legal  = 1'b1;
                dec_rs2    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                dec_funct7 = (instr_q[14:12] == 3'b101) ? instr_q[31:25] : 7'h00;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencer.
    // The ALU outputs change only on the DECODE->EXEC edge and otherwise hold.
    // The wb_valid and illegal outputs are registered single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            instr_q        <= '0;
            bus.alu_rs1    <= '0;
            bus.alu_rs2    <= '0;
            bus.alu_funct3 <= '0;
            bus.alu_funct7 <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_addr    <= '0;
            bus.wb_data    <= '0;
            bus.illegal    <= 1'b0;
`ifdef ALU_ZFLAG_EN
            z_flag         <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            bus.wb_valid <= 1'b0;
            bus.illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        bus.alu_rs1    <= dec_rs1;
                        bus.alu_rs2    <= dec_rs2;
                        bus.alu_funct3 <= dec_funct3;
                        bus.alu_funct7 <= dec_funct7;
                        state          <= EXEC;
                    end else begin
                        bus.illegal <= 1'b1;
                        state       <= IDLE;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                WB: begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_addr  <= instr_q[11:7];
                    bus.wb_data  <= bus.alu_rd;
                    if (instr_q[11:7] != 5'd0) begin
                        regs[instr_q[11:7]] <= bus.alu_rd;
                    end
`ifdef ALU_ZFLAG_EN
                    z_flag <= bus.alu_z;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue, paired with a behavioural registered ALU.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ALU_ZFLAG_EN
    logic        z_flag;
`endif

    int testsRun;
    int testsFailed;

    logic [31:0] exRs1;
    logic [31:0] exRs2;
    logic [2:0]  exF3;
    logic [6:0]  exF7;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32), .NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_ZFLAG_EN
        ,
        .z_flag   (z_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RV32I ALU: the result appears one cycle after the operands.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:  return f7[5] ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        bus.alu_rd <= aluModel(bus.alu_rs1, bus.alu_rs2, bus.alu_funct3, bus.alu_funct7);
        bus.alu_z  <= (aluModel(bus.alu_rs1, bus.alu_rs2, bus.alu_funct3, bus.alu_funct7) == 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge. Holds valid until accepted, then drops it after the accepting edge.
    task automatic applyStimulus(input logic [31:0] ins, output int waited);
        waited = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        while (!bus.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_timeout", 32'(waited < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
    endtask

    // Starts just after the accepting edge N. wb_valid must be low through edges N+1 and N+2.
    // It must be high for exactly the one cycle after edge N+3.
    task automatic observeWb(input string tag, input logic [4:0] expAddr, input logic [31:0] expData);
        logic early;
        early = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_busy"}, 32'(bus.instr_ready), 32'd0);
        early = early | bus.wb_valid | bus.illegal;
        @(negedge clk);
        exRs1 = bus.alu_rs1;
        exRs2 = bus.alu_rs2;
        exF3  = bus.alu_funct3;
        exF7  = bus.alu_funct7;
        early = early | bus.wb_valid | bus.illegal;
        @(negedge clk);
        early = early | bus.wb_valid | bus.illegal;
        checkOutput({tag, "_early"}, 32'(early), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_wbvalid"}, 32'(bus.wb_valid), 32'd1);
        checkOutput({tag, "_wbaddr"}, 32'(bus.wb_addr), 32'(expAddr));
        checkOutput({tag, "_wbdata"}, bus.wb_data, expData);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic observeIllegal(input string tag);
        @(negedge clk);
        checkOutput({tag, "_decode"}, 32'(bus.illegal), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(bus.illegal), 32'd1);
        checkOutput({tag, "_nowb1"}, 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_single"}, 32'(bus.illegal), 32'd0);
        checkOutput({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
        checkOutput({tag, "_nowb2"}, 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_nowb3"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(tag, dbg_data, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   waited;
        logic quiet;
        testsRun        = 0;
        testsFailed     = 0;
        rst             = 1'b1;
        dbg_addr        = 5'd1;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0140_0093;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready", 32'(bus.instr_ready), 32'd0);
        checkOutput("rst_wbvalid", 32'(bus.wb_valid), 32'd0);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
        checkOutput("rst_alu_rs1", bus.alu_rs1, 32'd0);
        checkOutput("rst_dbg1", dbg_data, 32'd0);

        // 1: addi x1,x0,20 held valid across reset release
        rst = 1'b0;
        #1;
        checkOutput("t1_ready_after_rst", 32'(bus.instr_ready), 32'd1);
        applyStimulus(32'h0140_0093, waited);
        checkOutput("t1_first_cycle", 32'(waited), 32'd0);
        observeWb("t1", 5'd1, 32'd20);
        checkReg("t1_x1", 5'd1, 32'd20);

        // 2: addi x2,x0,30 ; add x3,x1,x2 ; sub x4,x2,x1
        applyStimulus(32'h01E0_0113, waited);
        observeWb("t2_addi", 5'd2, 32'd30);
        applyStimulus(32'h0020_81B3, waited);
        observeWb("t2_add", 5'd3, 32'd50);
        checkOutput("t2_add_rs1", exRs1, 32'd20);
        checkOutput("t2_add_rs2", exRs2, 32'd30);
        checkOutput("t2_add_f3", 32'(exF3), 32'd0);
        checkOutput("t2_add_f7", 32'(exF7), 32'h00);
        applyStimulus(32'h4011_0233, waited);
        observeWb("t2_sub", 5'd4, 32'd10);
        checkOutput("t2_sub_f7", 32'(exF7), 32'h20);
        checkReg("t2_x3", 5'd3, 32'd50);

        // ALU outputs hold their last value while idle
        checkOutput("hold_rs1", bus.alu_rs1, 32'd30);
        checkOutput("hold_f7", 32'(bus.alu_funct7), 32'h20);

        // 3: xori x5,x1,-1 ; srai x6,x5,2
        applyStimulus(32'hFFF0_C293, waited);
        observeWb("t3_xori", 5'd5, 32'hFFFF_FFEB);
        checkOutput("t3_xori_rs2", exRs2, 32'hFFFF_FFFF);
        checkOutput("t3_xori_f7", 32'(exF7), 32'h00);
        applyStimulus(32'h4022_D313, waited);
        observeWb("t3_srai", 5'd6, 32'hFFFF_FFFA);
        checkOutput("t3_srai_f7", 32'(exF7), 32'h20);
        checkOutput("t3_srai_rs2", exRs2, 32'h0000_0402);
        checkOutput("t3_srai_f3", 32'(exF3), 32'd5);

        // addi x8,x1,1024: the immediate's top bits look like 0x20 but must not select SUB
        applyStimulus(32'h4000_8413, waited);
        observeWb("addi_nosub", 5'd8, 32'h0000_0414);
        checkOutput("addi_nosub_f7", 32'(exF7), 32'h00);

        // 4: addi x0,x0,5 still pulses writeback; x0 stays zero
        applyStimulus(32'h0050_0013, waited);
        observeWb("t4", 5'd0, 32'd5);
        checkReg("t4_x0", 5'd0, 32'd0);

        // 5: unsupported opcode, then an R-type op with funct7=0x01
        applyStimulus(32'h0000_007F, waited);
        observeIllegal("t5_opcode");
        applyStimulus(32'h0210_81B3, waited);
        observeIllegal("t5_funct7");
        checkReg("t5_x3_kept", 5'd3, 32'd50);

`ifdef ALU_ZFLAG_EN
        // sub x7,x1,x1 sets z_flag; it holds until the next writeback (addi x9,x0,1)
        checkOutput("z_reset", 32'(z_flag), 32'd0);
        applyStimulus(32'h4010_83B3, waited);
        observeWb("z_sub", 5'd7, 32'd0);
        checkOutput("z_set", 32'(z_flag), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("z_hold", 32'(z_flag), 32'd1);
        applyStimulus(32'h0010_0493, waited);
        observeWb("z_addi", 5'd9, 32'd1);
        checkOutput("z_clear", 32'(z_flag), 32'd0);
`endif

        // 6: reset during EXEC of add x3,x1,x2
        applyStimulus(32'h0020_81B3, waited);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_exec_rs1", bus.alu_rs1, 32'd20);
        rst = 1'b1;
        #1;
        checkOutput("t6_abort_rs1", bus.alu_rs1, 32'd0);
        quiet = bus.wb_valid | bus.illegal;
        repeat (2) begin
            @(negedge clk);
            quiet = quiet | bus.wb_valid | bus.illegal;
        end
        rst = 1'b0;
        #1;
        checkOutput("t6_ready_after_rst", 32'(bus.instr_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            quiet = quiet | bus.wb_valid | bus.illegal;
        end
        checkOutput("t6_no_pulse", 32'(quiet), 32'd0);
        checkReg("t6_x3", 5'd3, 32'd0);
        checkReg("t6_x1", 5'd1, 32'd0);

        // operation resumes after reset: addi x1,x0,7 ; add x3,x1,x2 (x2 was cleared)
        @(negedge clk);
        applyStimulus(32'h0070_0093, waited);
        observeWb("t6_addi", 5'd1, 32'd7);
        applyStimulus(32'h0020_81B3, waited);
        observeWb("t6_add", 5'd3, 32'd7);
        checkReg("t6_x3_new", 5'd3, 32'd7);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
